// File: rtl/fir_serial_mac.sv
`default_nettype none
// ============================================================================
//  Module   : fir_serial_mac
//  Purpose  : Time-multiplexed N-tap signed FIR filter. A single
//             multiplier/accumulator walks the delay line once per accepted
//             sample and emits one valid-flagged, saturated result per sample.
//             Coefficients are writable at runtime while the filter is idle.
//  Revision : 1.0  initial release
// ============================================================================
module fir_serial_mac #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int NTAPS     = 64,
  parameter int ACC_W     = 38,
  parameter int OUT_SHIFT = 0,
  parameter int COEF_RST  = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [DATA_W-1:0]          din,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]          coef_wdata,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid
);

  localparam int c_addr_w = $clog2(NTAPS);
  localparam int c_prod_w = DATA_W + COEF_W;

  localparam logic [c_addr_w-1:0] c_last_tap = c_addr_w'(NTAPS - 1);
  localparam logic [c_addr_w-1:0] c_one      = c_addr_w'(1);

  // Output clamp limits expressed at accumulator width
  localparam logic signed [ACC_W-1:0] c_sat_max =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_sat_min =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                     r_state;
  logic [c_addr_w-1:0]        r_wr_ptr;
  logic [c_addr_w-1:0]        r_tap;
  logic signed [ACC_W-1:0]    r_acc;
  logic [DATA_W-1:0]          r_dout;
  logic                       r_dout_valid;
  logic                       r_din_ready;

  logic signed [DATA_W-1:0]   r_x    [NTAPS];
  logic signed [COEF_W-1:0]   r_coef [NTAPS];

  logic                       w_accept;
  logic [c_addr_w-1:0]        w_rd_addr;
  logic signed [c_prod_w-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_shifted;
  logic [DATA_W-1:0]          w_sat;

  // din_ready is only ever high in IDLE, so it alone qualifies the handshake
  assign w_accept = din_valid & r_din_ready;

  // Newest sample sits just behind the write pointer; tap k reaches back k samples
  assign w_rd_addr  = r_wr_ptr - c_one - r_tap;
  assign w_prod     = r_coef[r_tap] * r_x[w_rd_addr];
  assign w_prod_ext = {{(ACC_W-c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
  assign w_shifted  = r_acc >>> OUT_SHIFT;

  // Clamp the scaled accumulator into the signed output range
  always_comb begin
    w_sat = w_shifted[DATA_W-1:0];
    if (w_shifted > c_sat_max) begin
      w_sat = c_sat_max[DATA_W-1:0];
    end else if (w_shifted < c_sat_min) begin
      w_sat = c_sat_min[DATA_W-1:0];
    end
  end

  // Control FSM: accept a sample, run NTAPS MAC cycles, publish the result
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_tap        <= '0;
      r_acc        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_din_ready  <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_din_ready <= 1'b0;
            r_wr_ptr    <= r_wr_ptr + c_one;
            r_acc       <= '0;
            r_tap       <= '0;
            r_state     <= S_MAC;
          end else begin
            r_din_ready <= 1'b1;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_tap <= r_tap + c_one;
          if (r_tap == c_last_tap) begin
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          r_dout       <= w_sat;
          r_dout_valid <= 1'b1;
          r_din_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_din_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Delay line: accepted sample lands at the write pointer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_x[i] <= '0;
      end
    end else if (w_accept) begin
      r_x[r_wr_ptr] <= din;
    end
  end

  // Coefficient bank: writes only land in IDLE so a result never mixes sets
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_coef[i] <= COEF_W'(COEF_RST);
      end
    end else if (coef_we && (r_state == S_IDLE)) begin
      r_coef[coef_addr] <= coef_wdata;
    end
  end

  assign din_ready  = r_din_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_fir_serial_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_serial_mac
//  Purpose  : Directed, table-driven self-checking bench for fir_serial_mac
//             (default parameters: 16-bit data/coefs, 64 taps, no shift).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_serial_mac;

  logic               clk;
  logic               resetn;
  logic [15:0]        din;
  logic               din_valid;
  logic               din_ready;
  logic               coef_we;
  logic [5:0]         coef_addr;
  logic [15:0]        coef_wdata;
  logic [15:0]        dout;
  logic               dout_valid;

  int n_pass;
  int n_total;

  typedef struct {
    int din;
    int exp;
  } vec_t;

  vec_t step_tab[40];
  vec_t neg_tab[2];

  fir_serial_mac dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called on the first negedge after the accept edge; lat = -1 on timeout
  task automatic wait_result(output int y, output int lat);
    int n;
    n = 1;
    while (!dout_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    y   = $signed(dout);
    lat = dout_valid ? n - 1 : -1;
  endtask

  task automatic send(input int v, output int y, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    din       = 16'(v);
    din_valid = 1'b1;
    while (!din_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    wait_result(y, lat);
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = 6'(addr);
    coef_wdata = 16'(val);
    @(negedge clk);
    coef_we    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn    = 1'b0;
    din_valid = 1'b0;
    coef_we   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_din_ready", int'(din_ready), 0);
    check("rst_dout", $signed(dout), 0);
    check("rst_dout_valid", int'(dout_valid), 0);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_release", int'(din_ready), 1);
  endtask

  initial begin
    int y, lat, seen, last, accepts, nres;

    n_pass     = 0;
    n_total    = 0;
    resetn     = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;

    for (int i = 0; i < 40; i++) begin
      step_tab[i].din = 1000;
      step_tab[i].exp = (i < 32) ? 1000 * (i + 1) : 32767;
    end
    neg_tab[0] = '{din: -32768, exp: -32768};
    neg_tab[1] = '{din: -32768, exp: -32768};

    // 1: reset defaults, impulse response with unity taps
    do_reset();
    send(100, y, lat);
    check("impulse_first", y, 100);
    check("impulse_latency", lat, 65);
    for (int i = 1; i < 64; i++) begin
      send(0, y, lat);
      check("impulse_tail", y, 100);
      check("impulse_tail_latency", lat, 65);
    end
    send(0, y, lat);
    check("impulse_drained", y, 0);

    // 2: step input, positive saturation
    do_reset();
    for (int i = 0; i < 40; i++) begin
      send(step_tab[i].din, y, lat);
      check("step", y, step_tab[i].exp);
    end

    // 3: negative saturation, then -1 * -32768 saturating positive
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send(neg_tab[i].din, y, lat);
      check("neg_sat", y, neg_tab[i].exp);
    end
    write_coef(0, -1);
    for (int k = 1; k < 64; k++) write_coef(k, 0);
    send(-32768, y, lat);
    check("neg_times_neg_sat", y, 32767);

    // 4: coefficient write timing
    do_reset();
    send(10, y, lat);
    check("coef_base", y, 10);
    @(negedge clk);
    din       = 16'(20);
    din_valid = 1'b1;
    check("ready_before_accept", int'(din_ready), 1);
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("ready_low_mac", int'(din_ready), 0);
    coef_we    = 1'b1;
    coef_addr  = 6'd0;
    coef_wdata = 16'(5);
    @(negedge clk);
    coef_we = 1'b0;
    wait_result(y, lat);
    check("coef_mid_mac_ignored", y, 30);
    @(negedge clk);
    din        = 16'(7);
    din_valid  = 1'b1;
    coef_we    = 1'b1;
    coef_addr  = 6'd1;
    coef_wdata = 16'(3);
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    coef_we   = 1'b0;
    wait_result(y, lat);
    check("coef_on_accept_edge", y, 77);

    // 5: din_valid held high -> one accept every 66 cycles
    do_reset();
    din       = 16'(1);
    din_valid = 1'b1;
    last      = -1;
    accepts   = 0;
    nres      = 0;
    for (int i = 0; i < 211; i++) begin
      if (i > 0) @(negedge clk);
      if (dout_valid) begin
        check("hold_valid_result", $signed(dout), nres + 1);
        nres++;
      end
      if (din_ready) begin
        if (last >= 0) check("accept_interval", i - last, 66);
        last = i;
        accepts++;
      end
    end
    din_valid = 1'b0;
    check("hold_valid_accepts", accepts, 4);
    check("hold_valid_results", nres, 3);

    // 6: reset during MAC discards the result and clears history
    do_reset();
    send(9, y, lat);
    check("pre_reset_sample", y, 9);
    @(negedge clk);
    din       = 16'(11);
    din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    seen      = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dout_valid) seen++;
    end
    resetn = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (dout_valid) seen++;
    end
    check("mid_mac_reset_dout", $signed(dout), 0);
    resetn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dout_valid) seen++;
    end
    check("mid_mac_no_valid", seen, 0);
    send(5, y, lat);
    check("history_cleared", y, 5);
    check("post_reset_latency", lat, 65);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
